// File: rtl/logic_cfg_loader.sv
// Serial configuration loader for the PP3 LOGIC cell: shifts a parity-protected
// word into a shadow register and commits it atomically to the active config.
module logic_cfg_loader #(
  parameter int CFG_BITS = 21,
  parameter int CNT_W    = 5
) (
  input  logic                QCK,
  input  logic                QRT_N,
  input  logic                START,
  input  logic                SEN,
  input  logic                SDI,
  output logic [CFG_BITS-1:0] CFG,
  output logic                CELL_EN,
  output logic                SDO,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, COMMIT} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_BITS - 1);

  state_t              state;
  logic [CFG_BITS-1:0] shadow;
  logic [CNT_W-1:0]    cnt;

  // Right shift with SDI entering at the MSB; written without a part-select so
  // that CFG_BITS=1 still elaborates.
  function automatic logic [CFG_BITS-1:0] shift_in(input logic [CFG_BITS-1:0] w,
                                                   input logic               s);
    logic [CFG_BITS-1:0] t;
    t = w >> 1;
    t[CFG_BITS-1] = s;
    return t;
  endfunction

  // High when the word plus its parity bit carries an odd number of ones.
  function automatic logic parity_bad(input logic [CFG_BITS-1:0] w,
                                      input logic               p);
    return ^{w, p};
  endfunction

  always_ff @(posedge QCK or negedge QRT_N) begin
    if (!QRT_N) begin
      state   <= IDLE;
      shadow  <= '0;
      cnt     <= '0;
      CFG     <= '0;
      CELL_EN <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state  <= SHIFT;
            shadow <= '0;
            cnt    <= '0;
            ERR    <= 1'b0;
            BUSY   <= 1'b1;
          end
        end

        SHIFT: begin
          if (START) begin
            // Abort-and-restart: ERR is visible for one cycle only.
            shadow <= '0;
            cnt    <= '0;
            ERR    <= 1'b1;
          end else begin
            ERR <= 1'b0;
            if (SEN) begin
              shadow <= shift_in(shadow, SDI);
              cnt    <= cnt + CNT_W'(1);
              if (cnt == LAST_BIT) begin
                state <= PARITY;
              end
            end
          end
        end

        PARITY: begin
          if (START) begin
            state  <= SHIFT;
            shadow <= '0;
            cnt    <= '0;
            ERR    <= 1'b1;
          end else begin
            ERR <= 1'b0;
            if (SEN) begin
              if (parity_bad(shadow, SDI)) begin
                state <= IDLE;
                ERR   <= 1'b1;
                BUSY  <= 1'b0;
              end else begin
                state <= COMMIT;
              end
            end
          end
        end

        COMMIT: begin
          CFG     <= shadow;
          CELL_EN <= 1'b1;
          DONE    <= 1'b1;
          // A START here opens the next frame on the same edge.
          if (START) begin
            state  <= SHIFT;
            shadow <= '0;
            cnt    <= '0;
            ERR    <= 1'b0;
            BUSY   <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  assign SDO = shadow[0];

endmodule

// File: tb/tb_logic_cfg_loader.sv
// Directed self-checking bench for logic_cfg_loader (CFG_BITS=21).
module tb_logic_cfg_loader;

  logic        QCK;
  logic        QRT_N;
  logic        START;
  logic        SEN;
  logic        SDI;
  logic [20:0] CFG;
  logic        CELL_EN;
  logic        SDO;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int nvec = 0;
  int nerr = 0;

  logic_cfg_loader #(.CFG_BITS(21), .CNT_W(5)) dut (
    .QCK    (QCK),
    .QRT_N  (QRT_N),
    .START  (START),
    .SEN    (SEN),
    .SDI    (SDI),
    .CFG    (CFG),
    .CELL_EN(CELL_EN),
    .SDO    (SDO),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  initial QCK = 1'b0;
  always #5 QCK = ~QCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge QCK);
    #1;
  endtask

  task automatic do_reset();
    QRT_N = 1'b0;
    START = 1'b0;
    SEN   = 1'b0;
    SDI   = 1'b0;
    tick();
    tick();
    QRT_N = 1'b1;
    tick();
  endtask

  task automatic start_frame();
    START = 1'b1;
    SEN   = 1'b0;
    tick();
    START = 1'b0;
  endtask

  task automatic shift_bits(input logic [20:0] d, input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        SEN = 1'b0;
        tick();
      end
      SEN = 1'b1;
      SDI = d[i];
      tick();
    end
    SEN = 1'b0;
  endtask

  task automatic send_parity(input logic [20:0] d, input bit flip);
    SEN = 1'b1;
    SDI = (^d) ^ flip;
    tick();
    SEN = 1'b0;
    SDI = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_cfg",   32'(CFG),     32'h0);
    chk("rst_cellen",32'(CELL_EN), 32'h0);
    chk("rst_sdo",   32'(SDO),     32'h0);
    chk("rst_busy",  32'(BUSY),    32'h0);
    chk("rst_done",  32'(DONE),    32'h0);
    chk("rst_err",   32'(ERR),     32'h0);

    // Valid frame 0x0A5A5A, even parity bit 0
    start_frame();
    chk("t1_busy_start", 32'(BUSY), 32'h1);
    shift_bits(21'h0A5A5A, 21, 1'b0);
    send_parity(21'h0A5A5A, 1'b0);
    chk("t1_cfg_pre",  32'(CFG),  32'h0);
    chk("t1_done_pre", 32'(DONE), 32'h0);
    tick();
    chk("t1_cfg",    32'(CFG),     32'h0A5A5A);
    chk("t1_done",   32'(DONE),    32'h1);
    chk("t1_cellen", 32'(CELL_EN), 32'h1);
    chk("t1_busy",   32'(BUSY),    32'h0);
    chk("t1_err",    32'(ERR),     32'h0);
    tick();
    chk("t1_done_off", 32'(DONE), 32'h0);

    // Same frame with a bad parity bit
    do_reset();
    start_frame();
    shift_bits(21'h0A5A5A, 21, 1'b0);
    send_parity(21'h0A5A5A, 1'b1);
    chk("t2_err",  32'(ERR),  32'h1);
    chk("t2_busy", 32'(BUSY), 32'h0);
    tick();
    chk("t2_done",     32'(DONE),    32'h0);
    chk("t2_cfg",      32'(CFG),     32'h0);
    chk("t2_cellen",   32'(CELL_EN), 32'h0);
    chk("t2_err_stky", 32'(ERR),     32'h1);
    start_frame();
    chk("t2_err_clr", 32'(ERR), 32'h0);

    // Full-ones load, then a stalled 0x000001 frame
    do_reset();
    start_frame();
    shift_bits(21'h1FFFFF, 21, 1'b0);
    send_parity(21'h1FFFFF, 1'b0);
    tick();
    chk("t3_cfg_a", 32'(CFG), 32'h1FFFFF);
    chk("t3_sdo_a", 32'(SDO), 32'h1);
    start_frame();
    chk("t3_sdo_clr", 32'(SDO), 32'h0);
    shift_bits(21'h000001, 21, 1'b1);
    chk("t3_cfg_hold", 32'(CFG), 32'h1FFFFF);
    chk("t3_sdo_b",    32'(SDO), 32'h1);
    send_parity(21'h000001, 1'b0);
    chk("t3_cfg_pre", 32'(CFG), 32'h1FFFFF);
    tick();
    chk("t3_cfg_b",  32'(CFG),  32'h000001);
    chk("t3_done_b", 32'(DONE), 32'h1);

    // Abort after 10 bits, then a clean frame
    do_reset();
    start_frame();
    shift_bits(21'h0003FF, 10, 1'b0);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("t4_err_abort", 32'(ERR),  32'h1);
    chk("t4_busy",      32'(BUSY), 32'h1);
    chk("t4_cfg_keep",  32'(CFG),  32'h0);
    tick();
    chk("t4_err_once", 32'(ERR), 32'h0);
    shift_bits(21'h0C3A71, 21, 1'b0);
    send_parity(21'h0C3A71, 1'b0);
    tick();
    chk("t4_cfg",  32'(CFG),  32'h0C3A71);
    chk("t4_done", 32'(DONE), 32'h1);
    chk("t4_err",  32'(ERR),  32'h0);

    // Asynchronous reset during bit 15 of a frame after a valid commit
    do_reset();
    start_frame();
    shift_bits(21'h0A5A5A, 21, 1'b0);
    send_parity(21'h0A5A5A, 1'b0);
    tick();
    chk("t5_cfg_pre", 32'(CFG), 32'h0A5A5A);
    start_frame();
    shift_bits(21'h1FFFFF, 15, 1'b0);
    SEN = 1'b1;
    SDI = 1'b1;
    #2;
    QRT_N = 1'b0;
    #1;
    chk("t5_cfg",    32'(CFG),     32'h0);
    chk("t5_cellen", 32'(CELL_EN), 32'h0);
    chk("t5_sdo",    32'(SDO),     32'h0);
    chk("t5_busy",   32'(BUSY),    32'h0);
    chk("t5_done",   32'(DONE),    32'h0);
    chk("t5_err",    32'(ERR),     32'h0);
    @(posedge QCK);
    #1;
    QRT_N = 1'b1;
    tick();
    tick();
    chk("t5_idle_busy", 32'(BUSY), 32'h0);
    chk("t5_idle_sdo",  32'(SDO),  32'h0);
    SEN = 1'b0;

    // START in the COMMIT cycle opens the next frame
    do_reset();
    start_frame();
    shift_bits(21'h0A5A5A, 21, 1'b0);
    send_parity(21'h0A5A5A, 1'b0);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("t6_done", 32'(DONE), 32'h1);
    chk("t6_busy", 32'(BUSY), 32'h1);
    chk("t6_cfg",  32'(CFG),  32'h0A5A5A);
    shift_bits(21'h155555, 21, 1'b0);
    send_parity(21'h155555, 1'b0);
    chk("t6_busy_par", 32'(BUSY), 32'h1);
    tick();
    chk("t6_cfg_b",  32'(CFG),  32'h155555);
    chk("t6_done_b", 32'(DONE), 32'h1);
    chk("t6_busy_b", 32'(BUSY), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
